// File: rtl/idex_pkg.sv
// Shared types and constants for the ID/EX pipeline stage: default widths,
// EX control-field layout, stage state encoding and the payload record.
package idex_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 2;
    localparam int DEF_EX_W   = 4;

    // EX control field layout: ALUSrc on top, RegDst at bit 0, ALUOp in between
    localparam int ALUSRC_BIT = DEF_EX_W - 1;
    localparam int ALUOP_MSB  = DEF_EX_W - 2;
    localparam int ALUOP_LSB  = 1;
    localparam int REGDST_BIT = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_BOTH  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [DEF_WB_W-1:0] wb;
        logic [DEF_M_W-1:0]  m;
        logic [DEF_EX_W-1:0] ex;
    } idex_ctrl_t;

    typedef struct packed {
        idex_ctrl_t            ctrl;
        logic [DEF_DATA_W-1:0] data1;
        logic [DEF_DATA_W-1:0] data2;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_REG_W-1:0]  rs;
        logic [DEF_REG_W-1:0]  rt;
        logic [DEF_REG_W-1:0]  rd;
    } idex_payload_t;

    localparam idex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/idex_pipe_stage_if.sv
// Decode-side and execute-side signals of the ID/EX stage; the stage uses the
// slave view, the surrounding pipeline (or a bench) uses the master view.
interface idex_pipe_stage_if
    import idex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int EX_W   = DEF_EX_W
) ();

    logic              valid_i;
    logic              ready_o;
    logic [WB_W-1:0]   WB_i;
    logic [M_W-1:0]    M_i;
    logic [EX_W-1:0]   EX_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [DATA_W-1:0] signextend_i;
    logic [REG_W-1:0]  rs_i;
    logic [REG_W-1:0]  rt_i;
    logic [REG_W-1:0]  rd_i;

    logic              valid_o;
    logic              ready_i;
    logic [WB_W-1:0]   WB_o;
    logic [M_W-1:0]    M_o;
    logic              ALUSrc_o;
    logic [EX_W-3:0]   ALUOp_o;
    logic              RegDst_o;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [DATA_W-1:0] signextend_o;
    logic [REG_W-1:0]  rs_o;
    logic [REG_W-1:0]  rt_o;
    logic [REG_W-1:0]  rd_o;

    modport slave (
        input  valid_i, WB_i, M_i, EX_i, data1_i, data2_i, signextend_i,
               rs_i, rt_i, rd_i, ready_i,
        output ready_o, valid_o, WB_o, M_o, ALUSrc_o, ALUOp_o, RegDst_o,
               data1_o, data2_o, signextend_o, rs_o, rt_o, rd_o
    );

    modport master (
        output valid_i, WB_i, M_i, EX_i, data1_i, data2_i, signextend_i,
               rs_i, rt_i, rd_i, ready_i,
        input  ready_o, valid_o, WB_o, M_o, ALUSrc_o, ALUOp_o, RegDst_o,
               data1_o, data2_o, signextend_o, rs_o, rt_o, rd_o
    );

endinterface

// File: rtl/idex_pipe_stage_pipe_slot.sv
// One payload register of the ID/EX stage: loads only when told to, and
// clears synchronously so reset leaves every held field at zero.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_o <= '0;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and an optional
// skid entry; control outputs are forced to zero whenever the slot is a bubble.
module idex_pipe_stage
    import idex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int EX_W   = DEF_EX_W,
    parameter int SKID   = 1
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic              flush_i,
    idex_pipe_stage_if.slave bus
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [EX_W-1:0]   ex;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } stage_payload_t;

    localparam int PW = $bits(stage_payload_t);

    stage_state_e   state_q, state_d;
    stage_payload_t in_d, m_d, m_q, s_q;
    logic           stage_valid, stage_ready, accept, consume;
    logic           m_load, s_load, m_from_s;

    assign in_d = '{wb: bus.WB_i, m: bus.M_i, ex: bus.EX_i,
                    data1: bus.data1_i, data2: bus.data2_i, imm: bus.signextend_i,
                    rs: bus.rs_i, rt: bus.rt_i, rd: bus.rd_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // BOTH is only reachable with a skid entry; without one, accept while full
    // always coincides with consume
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept && !consume && SKID != 0) state_d = ST_BOTH;
                    else if (consume && !accept)         state_d = ST_EMPTY;
                end
                ST_BOTH:  if (consume) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // With a skid entry ready depends only on the state flop, never on ready_i
    always_comb begin
        stage_valid = (state_q != ST_EMPTY);
        stage_ready = (SKID != 0) ? (state_q != ST_BOTH) : (bus.ready_i || !stage_valid);
        accept      = bus.valid_i && stage_ready;
        consume     = stage_valid && bus.ready_i;
        m_load      = 1'b0;
        s_load      = 1'b0;
        m_from_s    = 1'b0;
        if (!flush_i) begin
            case (state_q)
                ST_EMPTY: m_load = accept;
                ST_FULL: begin
                    m_load = accept && consume;
                    s_load = accept && !consume;
                end
                ST_BOTH: begin
                    m_load   = consume;
                    m_from_s = consume;
                end
                default: m_load = 1'b0;
            endcase
        end
    end

    assign m_d = m_from_s ? s_q : in_d;

    pipe_slot #(.W(PW)) u_main (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (m_load),
        .d_i    (m_d),
        .q_o    (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(PW)) u_skid (
                .clk_i  (clk_i),
                .clr_i  (rst_i),
                .load_i (s_load),
                .d_i    (in_d),
                .q_o    (s_q)
            );
        end else begin : g_no_skid
            assign s_q = '0;
        end
    endgenerate

    assign bus.valid_o      = stage_valid;
    assign bus.ready_o      = stage_ready;
    assign bus.WB_o         = stage_valid ? m_q.wb : '0;
    assign bus.M_o          = stage_valid ? m_q.m : '0;
    assign bus.ALUSrc_o     = stage_valid && m_q.ex[EX_W-1];
    assign bus.ALUOp_o      = stage_valid ? m_q.ex[EX_W-2:ALUOP_LSB] : '0;
    assign bus.RegDst_o     = stage_valid && m_q.ex[REGDST_BIT];
    assign bus.data1_o      = m_q.data1;
    assign bus.data2_o      = m_q.data2;
    assign bus.signextend_o = m_q.imm;
    assign bus.rs_o         = m_q.rs;
    assign bus.rt_o         = m_q.rt;
    assign bus.rd_o         = m_q.rd;

endmodule
